lsu: RTL and testbench
======================

# lsu

Load/store unit for the execute-to-memory boundary of the RISC-V core. It takes the ALU result as the effective address and drives a request/grant/response data-memory port. It formats store byte lanes, and extracts and sign- or zero-extends load data. It holds the pipeline with `busy` while an access is outstanding.

## Interface

Parameters:
- `D_WIDTH`, 32: data and address width. Only 32 is supported.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  a memory instruction is present this cycle; sampled only when `busy`=0.
- `ex_we`  in  1  1 = store, 0 = load.
- `ex_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ex_addr`  in  D_WIDTH  effective address (ALU result).
- `ex_wdata`  in  D_WIDTH  store data (rs2).
- `busy`  out  1  access outstanding; the pipeline must hold.
- `done`  out  1  one-cycle pulse when an access completes.
- `rd_data`  out  D_WIDTH  formatted load result; valid when `done` and the access was a load.
- `fault`  out  1  one-cycle pulse for a misaligned or illegal-width access.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  D_WIDTH  word address, with `[1:0]`=00.
- `mem_wdata`  out  D_WIDTH  lane-replicated store data.
- `mem_be`  out  4  byte enables.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  D_WIDTH  read data.

## Operation

- The FSM has three states: IDLE, REQ and WAIT.
- **Accept.** In IDLE with `ex_valid`=1, the access is checked first.
  - Legal and aligned: latch `we`, `funct3`, `addr[1:0]`, word address, lane data and `be`, then go to REQ.
  - Misaligned (H/HU/SH with `addr[0]`=1, W with `addr[1:0]`≠0) or illegal width (load 011/110/111; store ≥011): no request is issued. Pulse `fault` the next cycle and stay in IDLE.
- **REQ.** `mem_req`=1 and all `mem_*` outputs are held stable until `mem_gnt`=1.
  - Store with grant: go to IDLE and pulse `done` next cycle.
  - Load with grant: go to WAIT.
- **WAIT.** Wait for `mem_rvalid`.
  - On `mem_rvalid`=1: register the formatted `mem_rdata` into `rd_data`, pulse `done`, go to IDLE.
  - `mem_rvalid` is ignored outside WAIT.
- **Store lanes:**
  - SB: `be` = 0001 << `addr[1:0]`; data = byte replicated ×4.
  - SH: `be` = `addr[1]` ? 1100 : 0011; data = halfword ×2.
  - SW: `be` = 1111; data unchanged.
- **Load extraction:**
  - Byte select: `addr[1:0]`. Halfword select: `addr[1]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
  - Loads drive `mem_be` = 1111.
- `busy` = (state ≠ IDLE). `ex_*` inputs are ignored while `busy`=1.
- `rd_data` holds its last value until the next load completes.

## Timing

- All outputs are registered or decoded from state; there is no combinational path from `ex_*` to `mem_*`.
- Best-case latency, with the access accepted at edge T:
  - T+1: REQ with `mem_req`=1.
  - Store granted at T+1: `done` at T+2.
  - Load granted at T+1, `mem_rvalid` at T+2: `rd_data` and `done` at T+3.
- The earliest next acceptance is the cycle `done` is high, because `busy` is already 0 in that cycle.
- `fault` is asserted at T+1 and `busy` stays 0.
- Arbitrary `mem_gnt` and `mem_rvalid` stall durations are supported, with no timeout.
- **Reset**, including mid-access:
  - Asynchronously returns the FSM to IDLE.
  - Clears `busy`, `done`, `fault`, `mem_req`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata` and `rd_data` to 0.
  - A response arriving after reset is discarded.

## Structure

- Shared package `lsu_pkg`:
  - funct3 width enum (`LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`).
  - FSM state enum.
  - Constant `BE_ALL` = 4'b1111.
- Sub-module `lsu_align`: purely combinational, covering store lane/`be` generation, load extraction/extension, and the misalign/illegal check. It is instantiated once for stores and checks, with its load path fed from the latched offset.

## Test plan

- SW addr 0x100, data 0xDEADBEEF, `mem_gnt` at first REQ cycle -> `mem_addr` 0x100, `mem_be` 1111, `mem_wdata` 0xDEADBEEF; `done` at T+2.
- SB addr 0x103, data 0x000000A5 -> `mem_be` 1000, `mem_wdata` 0xA5A5A5A5; SH addr 0x102, data 0x1234 -> `be` 1100, `wdata` 0x12341234.
- LB addr 0x101, `mem_rdata` 0x0000F000 -> `rd_data` 0xFFFFFFF0; LBU on the same access -> 0x000000F0; LH addr 0x102, `mem_rdata` 0x8001_0000 -> 0xFFFF8001.
- LW addr 0x102 -> `fault` pulse at T+1, `mem_req` never asserted, `busy`=0; load funct3 011 -> `fault`.
- Load with `mem_gnt` delayed 3 cycles and `mem_rvalid` delayed 2 -> `mem_*` stable throughout REQ, `busy` high until `done`, `ex_valid` pulses during `busy` ignored.
- Assert `rst_n`=0 in WAIT, then deliver `mem_rvalid` -> all outputs 0 immediately, no `done`, and the next access completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I width codes, FSM states, byte-enable constant.
package lsu_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } ls_width_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Lane formatting for the LSU: store byte enables/replication, access legality, load extract/extend.
// Purely combinational; the store/check side and the load side have independent inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic        err,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be         = BE_ALL;
        lane_wdata = wdata;
        err        = 1'b0;
        case (funct3)
            LS_B: begin
                be         = 4'b0001 << off;
                lane_wdata = {4{wdata[7:0]}};
            end
            LS_H: begin
                be         = off[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                err        = off[0];
            end
            LS_W:    err = (off != 2'b00);
            // unsigned widths exist only for loads
            LS_BU:   err = we;
            LS_HU:   err = we | off[0];
            default: err = 1'b1;
        endcase
    end

    always_comb begin
        ld_byte = rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            LS_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LS_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LS_BU:   ld_data = {24'd0, ld_byte};
            LS_HU:   ld_data = {16'd0, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access from execute and runs it over a req/gnt/rvalid memory port.
// Latency: request the cycle after accept; store done 1 cycle after gnt, load done 1 cycle after rvalid.
// Backpressure: busy holds the pipeline while an access is outstanding; gnt/rvalid may stall indefinitely.
module lsu
    import lsu_pkg::*;
#(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic               ex_we,
    input  logic [2:0]         ex_funct3,
    input  logic [D_WIDTH-1:0] ex_addr,
    input  logic [D_WIDTH-1:0] ex_wdata,
    output logic               busy,
    output logic               done,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               fault,
    output logic               mem_req,
    output logic               mem_we,
    output logic [D_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    output logic [3:0]         mem_be,
    input  logic               mem_gnt,
    input  logic               mem_rvalid,
    input  logic [D_WIDTH-1:0] mem_rdata
);

    lsu_state_e         state, state_nxt;
    logic [2:0]         q_funct3;
    logic [1:0]         q_off;
    logic [3:0]         st_be;
    logic [D_WIDTH-1:0] st_wdata;
    logic [D_WIDTH-1:0] ld_data;
    logic               chk_err;

    // Load side works from the latched offset/width so mem_rdata formats the accepted access.
    lsu_align u_align (
        .we         (ex_we),
        .funct3     (ex_funct3),
        .off        (ex_addr[1:0]),
        .wdata      (ex_wdata),
        .ld_funct3  (q_funct3),
        .ld_off     (q_off),
        .rdata      (mem_rdata),
        .be         (st_be),
        .lane_wdata (st_wdata),
        .err        (chk_err),
        .ld_data    (ld_data)
    );

    assign busy    = (state != ST_IDLE);
    assign mem_req = (state == ST_REQ);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (ex_valid && !chk_err) state_nxt = ST_REQ;
            ST_REQ:  if (mem_gnt) state_nxt = mem_we ? ST_IDLE : ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            fault     <= 1'b0;
            rd_data   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            q_funct3  <= '0;
            q_off     <= '0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            if (state == ST_IDLE && ex_valid) begin
                if (chk_err) begin
                    fault <= 1'b1;
                end else begin
                    mem_we    <= ex_we;
                    mem_addr  <= {ex_addr[D_WIDTH-1:2], 2'b00};
                    mem_wdata <= st_wdata;
                    mem_be    <= ex_we ? st_be : BE_ALL;
                    q_funct3  <= ex_funct3;
                    q_off     <= ex_addr[1:0];
                end
            end
            if (state == ST_REQ && mem_gnt && mem_we) done <= 1'b1;
            if (state == ST_WAIT && mem_rvalid) begin
                rd_data <= ld_data;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed plus randomized bench for lsu; expectations come from an arithmetic model of the lane rules.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_we;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] rd_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;

    int          compares   = 0;
    int          mismatches = 0;
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    lsu #(.D_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_funct3  (ex_funct3),
        .ex_addr    (ex_addr),
        .ex_wdata   (ex_wdata),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            mismatches++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    task automatic scramble_ex();
        ex_we     = 1'($urandom_range(0, 1));
        ex_funct3 = 3'($urandom_range(0, 7));
        ex_addr   = $urandom;
        ex_wdata  = $urandom;
    endtask

    // One access; called at a negedge with the DUT idle. gd/rvd are stall cycles before gnt/rvalid.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int gd, input int rvd);
        int          sz, off, v;
        bit          bad;
        logic [31:0] ebe, ewd, eld, sh;
        sz  = size_of(f3);
        off = int'(addr[1:0]);
        bad = (sz == 0) || (we && f3[2]);
        if (!bad) bad = (off % sz) != 0;
        ebe = we ? 32'(((1 << sz) - 1) << off) : 32'hF;
        ewd = (sz == 1) ? wdata[7:0] * 32'h0101_0101 :
              (sz == 2) ? wdata[15:0] * 32'h0001_0001 : wdata;
        sh  = rdata >> (8 * off);
        eld = rdata;
        if (sz == 1) begin
            v = int'(sh & 32'hFF);
            if (!f3[2] && v >= 128) v -= 256;
            eld = 32'(v);
        end else if (sz == 2) begin
            v = int'(sh & 32'hFFFF);
            if (!f3[2] && v >= 32768) v -= 65536;
            eld = 32'(v);
        end

        ex_valid = 1'b1; ex_we = we; ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
        @(negedge clk);
        ex_valid = 1'b0;
        scramble_ex();
        if (bad) begin
            chk("fault_set", fault, 1);
            chk("fault_no_req", mem_req, 0);
            chk("fault_busy", busy, 0);
            @(negedge clk);
            chk("fault_pulse", fault, 0);
            chk("fault_no_done", done, 0);
            chk("fault_rd_hold", rd_data, exp_rd);
            return;
        end
        chk("no_fault", fault, 0);
        for (int i = 0; i <= gd; i++) begin
            chk("req", mem_req, 1);
            chk("busy_req", busy, 1);
            chk("addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("we", mem_we, we);
            chk("be", mem_be, ebe);
            if (we) chk("wdata", mem_wdata, ewd);
            if (i < gd) begin
                mem_gnt    = 1'b0;
                ex_valid   = 1'($urandom_range(0, 1));
                mem_rvalid = 1'($urandom_range(0, 1));
            end else begin
                mem_gnt    = 1'b1;
                ex_valid   = 1'b0;
                mem_rvalid = 1'b0;
            end
            @(negedge clk);
            ex_valid   = 1'b0;
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b0;
        end
        if (we) begin
            chk("st_done", done, 1);
            chk("st_busy", busy, 0);
            chk("st_rd_hold", rd_data, exp_rd);
        end else begin
            chk("ld_wait_done", done, 0);
            chk("ld_wait_busy", busy, 1);
            chk("ld_wait_req", mem_req, 0);
            for (int i = 0; i < rvd; i++) begin
                mem_gnt  = 1'($urandom_range(0, 1));
                ex_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                ex_valid = 1'b0;
                mem_gnt  = 1'b0;
                chk("ld_stall_busy", busy, 1);
                chk("ld_stall_done", done, 0);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            exp_rd     = eld;
            chk("ld_done", done, 1);
            chk("ld_busy", busy, 0);
            chk("ld_data", rd_data, exp_rd);
        end
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("rd_hold", rd_data, exp_rd);
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ex_we = 1'b0; ex_funct3 = 3'd0;
        ex_addr = '0; ex_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        exp_rd = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0);
        access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0);
        access(1'b1, 3'b001, 32'h102, 32'h0000_1234, 32'h0, 1, 0);
        access(1'b0, 3'b000, 32'h101, 32'h0, 32'h0000_F000, 0, 0);
        access(1'b0, 3'b100, 32'h101, 32'h0, 32'h0000_F000, 0, 0);
        access(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 0, 0);
        access(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
        access(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0);
        access(1'b1, 3'b100, 32'h100, 32'h55, 32'h0, 0, 0);
        access(1'b0, 3'b010, 32'h200, 32'h0, 32'hCAFE_F00D, 3, 2);

        for (int n = 0; n < 60; n++)
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                   $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

        // Reset while a load waits for its response
        ex_valid = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h300; ex_wdata = '0;
        @(negedge clk);
        ex_valid = 1'b0;
        mem_gnt  = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_fault", fault, 0);
        chk("arst_req", mem_req, 0);
        chk("arst_we", mem_we, 0);
        chk("arst_be", mem_be, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_wdata", mem_wdata, 0);
        chk("arst_rd", rd_data, 0);
        exp_rd = '0;
        @(negedge clk);
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rsp_done", done, 0);
        chk("late_rsp_rd", rd_data, 0);
        chk("late_rsp_busy", busy, 0);
        access(1'b0, 3'b101, 32'h402, 32'h0, 32'h9ABC_0000, 1, 1);
        access(1'b1, 3'b010, 32'h404, 32'h0BAD_CAFE, 32'h0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
